// File: rtl/piso_stream.sv
// Parallel-in/serial-out serializer with valid/ready handshakes on both sides.
// Emits each captured word as DEPTH chunks, MSB- or LSB-first per word, with zero-bubble reload.
module piso_stream #(
  parameter int unsigned DATA_IN_W  = 8,
  parameter int unsigned DATA_OUT_W = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_IN_W-1:0]  i_data,
  input  logic                  i_msb_first,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_OUT_W-1:0] o_data,
  output logic                  o_first,
  output logic                  o_last,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int unsigned DEPTH = DATA_IN_W / DATA_OUT_W;
  localparam int unsigned CNT_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEPTH - 1);

  if (DEPTH < 2 || DEPTH * DATA_OUT_W != DATA_IN_W) begin : g_bad_params
    $error("piso_stream: DATA_IN_W must be a multiple (>= 2x) of DATA_OUT_W");
  end

  typedef enum logic {StIdle, StShift} state_e;

  state_e                 r_state;
  state_e                 w_state_next;
  logic [CNT_W-1:0]       r_count;
  logic [CNT_W-1:0]       w_count_next;
  logic [DATA_IN_W-1:0]   r_word;
  logic                   r_msb_first;
  logic                   r_done;

  logic                   w_load;
  logic                   w_beat;
  logic                   w_last;
  logic [CNT_W-1:0]       w_sel;
  logic [DEPTH-1:0][DATA_OUT_W-1:0] w_chunks;

  assign o_valid = (r_state == StShift);
  assign o_busy  = o_valid;
  assign w_last  = (r_count == LAST_CNT);
  assign w_beat  = o_valid & i_ready;
  // Ready during the final beat lets the next word load without a bubble.
  assign o_ready = ~i_rst & ((r_state == StIdle) | (w_beat & w_last));
  assign w_load  = i_valid & o_ready;

  assign o_first = o_valid & (r_count == '0);
  assign o_last  = o_valid & w_last;
  assign o_done  = r_done;

  // Chunk DEPTH-1 holds the word's top bits, so MSB-first walks the chunk index downward.
  assign w_chunks = r_word;
  assign w_sel    = r_msb_first ? (LAST_CNT - r_count) : r_count;
  assign o_data   = o_valid ? w_chunks[w_sel] : '0;

  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    unique case (r_state)
      StIdle: begin
        if (w_load) begin
          w_state_next = StShift;
          w_count_next = '0;
        end
      end
      StShift: begin
        if (w_beat) begin
          if (w_last) begin
            w_count_next = '0;
            w_state_next = w_load ? StShift : StIdle;
          end else begin
            w_count_next = r_count + 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_count     <= '0;
      r_word      <= '0;
      r_msb_first <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
      r_done  <= w_beat & w_last;
      if (w_load) begin
        r_word      <= i_data;
        r_msb_first <= i_msb_first;
      end
    end
  end

endmodule

// File: tb/tb_piso_stream.sv
// Self-checking bench for piso_stream: directed scenarios plus random traffic on an 8/1 instance
// against a queue-of-chunks reference model, and directed order checks on a 16/4 instance.
module tb_piso_stream;

  localparam int unsigned DinW  = 8;
  localparam int unsigned DoutW = 1;
  localparam int unsigned Depth = DinW / DoutW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, valid, msb, rdy_in;
  logic [DinW-1:0]  data;
  logic             o_ready, o_valid, o_first, o_last, o_busy, o_done;
  logic [DoutW-1:0] o_data;

  logic        b_valid, b_msb, b_rdy;
  logic [15:0] b_data;
  logic        b_o_ready, b_o_valid, b_o_first, b_o_last, b_o_busy, b_o_done;
  logic [3:0]  b_o_data;

  piso_stream #(.DATA_IN_W(DinW), .DATA_OUT_W(DoutW)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(o_ready), .i_data(data),
    .i_msb_first(msb), .o_valid(o_valid), .i_ready(rdy_in), .o_data(o_data),
    .o_first(o_first), .o_last(o_last), .o_busy(o_busy), .o_done(o_done)
  );

  piso_stream #(.DATA_IN_W(16), .DATA_OUT_W(4)) u_dut_b (
    .i_clk(clk), .i_rst(rst), .i_valid(b_valid), .o_ready(b_o_ready), .i_data(b_data),
    .i_msb_first(b_msb), .o_valid(b_o_valid), .i_ready(b_rdy), .o_data(b_o_data),
    .o_first(b_o_first), .o_last(b_o_last), .o_busy(b_o_busy), .o_done(b_o_done)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: chunks of the held word still to be emitted, in emission order.
  logic [DoutW-1:0] m_q[$];
  bit               m_done = 1'b0;

  logic [15:0] cap;
  int          rdy_cnt, vld_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit r, input bit v, input logic [DinW-1:0] d, input bit m,
                      input bit ir);
    bit               e_valid, e_ready, beat, load;
    logic [DoutW-1:0] e_data;
    logic [DinW-1:0]  sh;
    @(negedge clk);
    rst = r; valid = v; data = d; msb = m; rdy_in = ir;
    #1;
    e_valid = (m_q.size() != 0);
    e_data  = e_valid ? m_q[0] : '0;
    e_ready = !r && (!e_valid || (ir && m_q.size() == 1));
    check("valid", o_valid, e_valid);
    check("busy",  o_busy,  e_valid);
    check("data",  o_data,  e_data);
    check("first", o_first, e_valid && m_q.size() == Depth);
    check("last",  o_last,  e_valid && m_q.size() == 1);
    check("ready", o_ready, e_ready);
    check("done",  o_done,  m_done);
    if (o_valid && ir) cap = {cap[14:0], o_data};
    if (o_ready) rdy_cnt++;
    if (o_valid) vld_cnt++;
    if (r) begin
      m_q.delete();
      m_done = 1'b0;
    end else begin
      beat   = e_valid && ir;
      load   = v && e_ready;
      m_done = beat && m_q.size() == 1;
      if (beat) e_data = m_q.pop_front();
      if (load) begin
        for (int i = 0; i < Depth; i++) begin
          sh = d >> ((m ? (Depth - 1 - i) : i) * DoutW);
          m_q.push_back(sh[DoutW-1:0]);
        end
      end
    end
  endtask

  task automatic run_b(input logic [15:0] d, input bit m, output logic [15:0] res);
    int n;
    res = '0;
    n   = 0;
    @(negedge clk);
    b_valid = 1'b1; b_data = d; b_msb = m; b_rdy = 1'b1;
    #1;
    check("b_ready", b_o_ready, 1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      b_valid = 1'b0;
      #1;
      if (b_o_valid) begin
        if (n == 0) check("b_first", b_o_first, 1);
        if (n == 3) check("b_last", b_o_last, 1);
        res = {res[11:0], b_o_data};
        n++;
      end
    end
    check("b_beats", n, 4);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] res;
    rst = 1'b1; valid = 1'b0; data = '0; msb = 1'b0; rdy_in = 1'b0;
    b_valid = 1'b0; b_data = '0; b_msb = 1'b0; b_rdy = 1'b0;
    repeat (2) @(posedge clk);

    // Reset state, then idle.
    step(1, 1, 8'hAA, 1, 1);
    step(0, 0, 8'h00, 0, 1);

    // Single word MSB-first.
    cap = '0;
    step(0, 1, 8'hA5, 1, 1);
    repeat (8) step(0, 0, 8'h00, 1, 1);
    step(0, 0, 8'h00, 1, 1);
    check("a5_seq", cap[7:0], 8'hA5);

    // Back-to-back words with i_valid held.
    cap = '0; rdy_cnt = 0; vld_cnt = 0;
    step(0, 1, 8'hF0, 1, 1);
    rdy_cnt = 0; vld_cnt = 0;
    repeat (8) step(0, 1, 8'h0F, 1, 1);
    check("b2b_ready_cnt", rdy_cnt, 1);
    repeat (8) step(0, 0, 8'h00, 1, 1);
    check("b2b_valid_cnt", vld_cnt, 16);
    check("b2b_seq", cap, 16'hF00F);
    step(0, 0, 8'h00, 1, 1);

    // Backpressure at beat 2.
    cap = '0;
    step(0, 1, 8'hC3, 1, 1);
    repeat (2) step(0, 0, 8'h00, 1, 1);
    repeat (3) step(0, 0, 8'h00, 1, 0);
    repeat (6) step(0, 0, 8'h00, 1, 1);
    step(0, 0, 8'h00, 1, 1);
    check("bp_seq", cap[7:0], 8'hC3);

    // Order flag toggled mid-word has no effect; next word uses the new mode.
    cap = '0;
    step(0, 1, 8'h81, 1, 1);
    repeat (3) step(0, 0, 8'h00, 1, 1);
    repeat (5) step(0, 0, 8'h00, 0, 1);
    check("mode_seq", cap[7:0], 8'h81);
    cap = '0;
    step(0, 1, 8'h01, 0, 1);
    repeat (8) step(0, 0, 8'h00, 0, 1);
    check("mode_next", cap[7:0], 8'h80);

    // Reset mid-word.
    step(0, 1, 8'hFF, 1, 1);
    repeat (4) step(0, 0, 8'h00, 1, 1);
    step(1, 0, 8'h00, 1, 1);
    step(0, 0, 8'h00, 1, 1);
    check("rst_ready", o_ready, 1);
    cap = '0;
    step(0, 1, 8'h5A, 1, 1);
    repeat (8) step(0, 0, 8'h00, 1, 1);
    check("rst_next_seq", cap[7:0], 8'h5A);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 9) < 6), 8'($urandom),
           1'($urandom), ($urandom_range(0, 9) < 7));
    end
    step(0, 0, 8'h00, 0, 1);

    // 16/4 instance: chunk order per word.
    run_b(16'h1234, 1'b0, res);
    check("b_lsb", res, 16'h4321);
    run_b(16'h1234, 1'b1, res);
    check("b_msb", res, 16'h1234);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/piso_stream.md
Name: piso_stream

Overview:
- Parametrised parallel-in/serial-out serializer with full valid/ready handshakes on both sides.
- Accepts one DATA_IN_W word and emits it as DEPTH = DATA_IN_W/DATA_OUT_W chunks.
- Chunk order (MSB-first or LSB-first) is selectable per word. Supports back-to-back words with no bubble and downstream backpressure.
- Used as the generic serializer in front of I2C/serial PHY shifters and width-reducing datapaths.

Parameters:
- DATA_IN_W, 8, parallel input word width; must be an integer multiple of DATA_OUT_W.
- DATA_OUT_W, 1, serial chunk width per output beat.
- DEPTH, DATA_IN_W/DATA_OUT_W (derived, localparam), chunks per word; must be >= 2.
- CNT_W, $clog2(DEPTH) (derived, localparam), beat counter width.

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_rst  in  1  synchronous reset, active-high.
- i_valid  in  1  upstream word valid.
- o_ready  out  1  serializer can accept a word this cycle.
- i_data  in  DATA_IN_W  parallel word; captured on i_valid & o_ready.
- i_msb_first  in  1  chunk order for the captured word; captured with i_data.
- o_valid  out  1  o_data holds a valid chunk.
- i_ready  in  1  downstream accepts the chunk this cycle.
- o_data  out  DATA_OUT_W  current chunk; forced to 0 when o_valid=0.
- o_first  out  1  current chunk is chunk 0 of the word (qualified by o_valid).
- o_last  out  1  current chunk is chunk DEPTH-1 (qualified by o_valid).
- o_busy  out  1  a word is held (state SHIFT).
- o_done  out  1  one-cycle pulse the cycle after the last chunk handshake of a word.

Behaviour:
- Reset (i_rst=1 at posedge): state=IDLE, count=0, word register=0, order flag=0, o_valid=0, o_done=0, o_busy=0, o_data=0, o_first=0, o_last=0. o_ready is forced to 0 while i_rst is high.
- Handshakes: load = i_valid & o_ready; beat = o_valid & i_ready.
- States are IDLE and SHIFT; o_valid = (state==SHIFT); o_busy = o_valid.
- o_ready = ~i_rst & (state==IDLE | (beat & count==DEPTH-1)), so a new word can load during the last beat of the previous word.
- IDLE -> SHIFT on load: register i_data and i_msb_first; count <= 0. Latency: the first chunk is presented the cycle after load.
- In SHIFT:
  - On beat with count < DEPTH-1: count <= count+1.
  - On beat with count == DEPTH-1 and load: stay in SHIFT, count <= 0, new word and order flag captured (zero-bubble).
  - On beat with count == DEPTH-1 and no load: go to IDLE, count <= 0.
  - With no beat: count, word and o_data hold stable (backpressure); o_valid never drops without a beat.
- Chunk select, with k = count:
  - MSB-first: o_data = word[DATA_IN_W-1-k*DATA_OUT_W -: DATA_OUT_W].
  - LSB-first: o_data = word[k*DATA_OUT_W +: DATA_OUT_W].
  - Combinational from registered word/count; no arithmetic overflow, since count never exceeds DEPTH-1.
- Flags: o_first = o_valid & (count==0); o_last = o_valid & (count==DEPTH-1).
- o_done is registered: o_done <= beat & (count==DEPTH-1). It pulses for exactly one cycle per completed word, including when the next word was loaded in the same cycle.
- i_msb_first and i_data are ignored when no load occurs; a mode change mid-word has no effect on that word.
- i_valid in SHIFT before the last beat is not accepted (o_ready=0); upstream must hold its word.
- Reset mid-word: the held word is discarded with no o_done. The next cycle after reset deasserts is IDLE with o_ready=1.
- No X propagation: every register has a reset value, and o_data=0 whenever o_valid=0.

Test Plan:
- Single word, defaults: i_data=8'hA5, i_msb_first=1, i_ready=1 -> o_data 1,0,1,0,0,1,0,1 on 8 consecutive cycles starting 1 cycle after load. o_first on beat 0, o_last on beat 7, o_done pulse 1 cycle after beat 7, then IDLE.
- LSB-first, DATA_IN_W=16, DATA_OUT_W=4: i_data=16'h1234, i_msb_first=0 -> chunks 4,3,2,1. Repeat with i_msb_first=1 -> chunks 1,2,3,4.
- Back-to-back: hold i_valid=1 with words 8'hF0 then 8'h0F, i_ready=1 -> 16 contiguous beats with o_valid never low. o_ready high only on the beat-7 cycle. Two o_done pulses, 8 cycles apart.
- Backpressure: 8'hC3 MSB-first; drop i_ready for 3 cycles at beat 2 -> o_data holds 0, count holds, o_valid stays 1. Sequence completes intact; o_done arrives 3 cycles later than the unstalled case.
- Mode change mid-word: load 8'h81 MSB-first, toggle i_msb_first at beat 3 -> output remains 1,0,0,0,0,0,0,1. The next word loaded uses the new mode.
- Reset mid-word: assert i_rst at beat 4 of 8'hFF -> next cycle o_valid=0, o_data=0, no o_done. After release o_ready=1, and a new word serializes from chunk 0.
